// File: rtl/frequency_pattern_generator.sv
// rtl/frequency_pattern_generator.sv - two-tone square-wave stimulus generator
// Alternates F1/F2 carriers for programmed durations, repeated N times or until stopped.
module frequency_pattern_generator #(
  parameter int unsigned FREQUENCY_1 = 9000,
  parameter int unsigned FREQUENCY_2 = 11000,
  parameter int unsigned CLOCK       = 100000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] f1_time,
  input  logic [31:0] f2_time,
  input  logic [15:0] repeat_count,
  output logic        sample_data,
  output logic        busy,
  output logic        phase,
  output logic        done,
  output logic [15:0] cycles_done
);

  localparam int unsigned HALF1 = CLOCK / (2 * FREQUENCY_1);
  localparam int unsigned HALF2 = CLOCK / (2 * FREQUENCY_2);
  localparam logic [31:0] HALF1_LAST = 32'(HALF1 - 1);
  localparam logic [31:0] HALF2_LAST = 32'(HALF2 - 1);

  if (HALF1 == 0 || HALF2 == 0) begin : g_half_check
    $error("frequency_pattern_generator: half period rounds to zero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_F1   = 2'd1,
    S_F2   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] f1_q, f2_q;
  logic [15:0] repeat_q;
  logic [31:0] dur_q;
  logic [31:0] half_q;
  logic        sample_q, busy_q, phase_q, done_q;
  logic [15:0] cycles_q;

  logic        enter_d;
  logic        end_cycle_d;
  logic [15:0] cycles_inc_d;
  logic        run_over_d;
  logic [31:0] f1_eff_d, f2_eff_d;
  logic [31:0] dur_load_d;
  logic [31:0] half_last_d;

  // In IDLE the live inputs drive the decision; they are latched on the same edge.
  always_comb begin
    f1_eff_d     = (state_q == S_IDLE) ? f1_time : f1_q;
    f2_eff_d     = (state_q == S_IDLE) ? f2_time : f2_q;
    cycles_inc_d = cycles_q + 16'd1;
    run_over_d   = (repeat_q != 16'd0) && (cycles_inc_d == repeat_q);
    half_last_d  = (state_q == S_F2) ? HALF2_LAST : HALF1_LAST;
    state_d      = state_q;
    enter_d      = 1'b0;
    end_cycle_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && f1_time != 32'd0) begin
          state_d = S_F1;
          enter_d = 1'b1;
        end else if (start && f2_time != 32'd0) begin
          state_d = S_F2;
          enter_d = 1'b1;
        end
      end
      S_F1: begin
        if (dur_q == 32'd0) begin
          if (f2_q != 32'd0) begin
            state_d = S_F2;
            enter_d = 1'b1;
          end else begin
            end_cycle_d = 1'b1;
          end
        end
      end
      S_F2: begin
        if (dur_q == 32'd0) end_cycle_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_cycle_d) begin
      enter_d = !run_over_d;
      if (run_over_d)            state_d = S_IDLE;
      else if (f1_q != 32'd0)    state_d = S_F1;
      else                       state_d = S_F2;
    end

    if (stop) begin
      state_d     = S_IDLE;
      enter_d     = 1'b0;
      end_cycle_d = 1'b0;
    end

    dur_load_d = ((state_d == S_F2) ? f2_eff_d : f1_eff_d) - 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      f1_q     <= '0;
      f2_q     <= '0;
      repeat_q <= '0;
      dur_q    <= '0;
      half_q   <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      phase_q  <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;

      if (state_q == S_IDLE && state_d != S_IDLE) begin
        f1_q     <= f1_time;
        f2_q     <= f2_time;
        repeat_q <= repeat_count;
        cycles_q <= '0;
      end else if (end_cycle_d) begin
        cycles_q <= cycles_inc_d;
      end

      if (enter_d) begin
        // Every phase restarts high with a fresh half-period count.
        dur_q    <= dur_load_d;
        half_q   <= '0;
        sample_q <= 1'b1;
        busy_q   <= 1'b1;
        phase_q  <= (state_d == S_F2);
      end else if (state_d == S_IDLE) begin
        sample_q <= 1'b0;
        busy_q   <= 1'b0;
        phase_q  <= 1'b0;
        done_q   <= end_cycle_d;
      end else begin
        dur_q <= dur_q - 32'd1;
        if (half_q == half_last_d) begin
          half_q   <= '0;
          sample_q <= ~sample_q;
        end else begin
          half_q <= half_q + 32'd1;
        end
      end
    end
  end

  assign sample_data = sample_q;
  assign busy        = busy_q;
  assign phase       = phase_q;
  assign done        = done_q;
  assign cycles_done = cycles_q;

endmodule

// File: tb/tb_frequency_pattern_generator.sv
// tb/tb_frequency_pattern_generator.sv - scoreboard bench for frequency_pattern_generator
module tb_frequency_pattern_generator;

  localparam int H1 = 5;
  localparam int H2 = 2;

  logic        clock = 1'b0;
  logic        reset, start, stop;
  logic [31:0] f1_time, f2_time;
  logic [15:0] repeat_count;
  logic        sample_data, busy, phase, done;
  logic [15:0] cycles_done;

  frequency_pattern_generator #(
    .FREQUENCY_1(10),
    .FREQUENCY_2(25),
    .CLOCK      (100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .f1_time     (f1_time),
    .f2_time     (f2_time),
    .repeat_count(repeat_count),
    .sample_data (sample_data),
    .busy        (busy),
    .phase       (phase),
    .done        (done),
    .cycles_done (cycles_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected output word: {sample_data, busy, phase, done, cycles_done}
  typedef struct {
    int          at;
    logic [19:0] want;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [19:0] pack(logic s, logic b, logic p, logic d, logic [15:0] c);
    return {s, b, p, d, c};
  endfunction

  // Output during cycle k (0-based) of an unstopped run.
  function automatic logic [19:0] run_model(int k, int f1, int f2);
    int per, i, r;
    per = f1 + f2;
    i   = k / per;
    r   = k % per;
    if (r < f1) return pack(((r / H1) % 2) == 0, 1'b1, 1'b0, 1'b0, 16'(i));
    return pack((((r - f1) / H2) % 2) == 0, 1'b1, 1'b1, 1'b0, 16'(i));
  endfunction

  task automatic expect_at(int at, logic [19:0] want, string tag);
    exp_t e;
    e.at   = at;
    e.want = want;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  exp_t        e_m;
  logic [19:0] act_m;
  always @(negedge clock) begin
    act_m = {sample_data, busy, phase, done, cycles_done};
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e_m = sb.pop_front();
      n_cmp++;
      if (e_m.at != cyc) begin
        n_bad++;
        $display("FAIL %s: cycle %0d not sampled (now %0d)", e_m.tag, e_m.at, cyc);
      end else if (act_m !== e_m.want) begin
        n_bad++;
        $display("FAIL %s @%0d: got s=%b b=%b p=%b d=%b cd=%0d, expected s=%b b=%b p=%b d=%b cd=%0d",
                 e_m.tag, cyc, act_m[19], act_m[18], act_m[17], act_m[16], act_m[15:0],
                 e_m.want[19], e_m.want[18], e_m.want[17], e_m.want[16], e_m.want[15:0]);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic launch(int f1, int f2, int rep);
    f1_time      = 32'(f1);
    f2_time      = 32'(f2);
    repeat_count = 16'(rep);
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  task automatic run_check(int f1, int f2, int rep, string tag);
    int s, total;
    s     = cyc;
    total = rep * (f1 + f2);
    for (int k = 0; k < total; k++) expect_at(s + 1 + k, run_model(k, f1, f2), tag);
    expect_at(s + total + 1, pack(1'b0, 1'b0, 1'b0, 1'b1, 16'(rep)), {tag, "_done"});
    expect_at(s + total + 2, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'(rep)), {tag, "_idle"});
    launch(f1, f2, rep);
    tick(total + 2);
  endtask

  int s;
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    f1_time      = '0;
    f2_time      = '0;
    repeat_count = '0;

    for (int k = 1; k <= 3; k++) expect_at(k, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'd0), "reset_state");
    tick(2);
    reset = 1'b0;
    tick(2);

    run_check(20, 8, 1, "basic");
    tick(1);
    run_check(20, 8, 3, "repeat3");
    tick(2);
    run_check(0, 6, 2, "zero_f1");

    // Both durations zero: start is not accepted, cycles_done keeps its value.
    s = cyc;
    for (int k = 1; k <= 3; k++) expect_at(s + k, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'd2), "zero_both");
    launch(0, 0, 1);
    tick(3);

    // Continuous run aborted by stop in the second cycle's F1 phase.
    s = cyc;
    for (int k = 0; k < 30; k++) expect_at(s + 1 + k, run_model(k, 20, 8), "stop_run");
    expect_at(s + 31, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'd1), "stop_abort");
    launch(20, 8, 0);
    tick(29);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;

    s = cyc;
    for (int k = 1; k <= 3; k++) expect_at(s + k, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'd1), "start_stop_pair");
    f1_time      = 32'd20;
    f2_time      = 32'd8;
    repeat_count = 16'd1;
    start        = 1'b1;
    stop         = 1'b1;
    tick(1);
    start        = 1'b0;
    stop         = 1'b0;
    tick(3);

    // Start while busy (with new times) is ignored; reset mid-run clears everything.
    s = cyc;
    for (int k = 0; k < 10; k++) expect_at(s + 1 + k, run_model(k, 20, 8), "busy_start");
    expect_at(s + 11, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'd0), "mid_reset");
    expect_at(s + 12, pack(1'b0, 1'b0, 1'b0, 1'b0, 16'd0), "post_reset");
    launch(20, 8, 1);
    tick(3);
    f1_time = 32'd7;
    f2_time = 32'd3;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
